axil_fifo_master: RTL and testbench
===================================

# axil_fifo_master

Bridge from a valid/ready request stream to an AXI4-Lite master port, the initiator-side counterpart of the AXI-lite FIFO client used in front of the Ethernet controller. A local agent presents addr/data/write/wmask requests. The block issues one AXI-lite read or write at a time, then returns the read data or write completion, with an error flag, on a valid/ready response stream. It sits between PL-side engines (DMA/descriptor fetch) and any AXI-lite slave, including the Ethernet CSR block.

## Interface
- axil_data_width_p, 32, AXI-lite data width (32 or 64)
- axil_addr_width_p, 32, AXI-lite address width
- axil_mask_width_lp, axil_data_width_p/8, write strobe width (derived)

Ports:
- clk_i  in  1  single clock; all logic on rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- addr_i  in  axil_addr_width_p  request address
- data_i  in  axil_data_width_p  write data
- w_i  in  1  1 = write, 0 = read
- wmask_i  in  axil_mask_width_lp  byte strobes (writes only)
- v_i  in  1  request valid
- ready_and_o  out  1  request accept
- data_o  out  axil_data_width_p  read data (0 for writes)
- err_o  out  1  slave returned non-OKAY (bresp/rresp != 2'b00)
- v_o  out  1  response valid
- ready_and_i  in  1  response accept
- m_axil_aw{addr,prot,valid}_o / awready_i; w{data,strb,valid}_o / wready_i; bresp_i, bvalid_i / bready_o; ar{addr,prot,valid}_o / arready_i; rdata_i, rresp_i, rvalid_i / rready_o — standard AXI4-Lite master, widths per parameters

## Operation
- Single outstanding transaction. FSM states: IDLE, WRITE, WRESP, RADDR, RDATA, RESP.
- IDLE: ready_and_o=1. On v_i&ready_and_o, capture addr/data/wmask/w into registers. Go to WRITE if w_i=1, else RADDR.
- WRITE: awvalid_o and wvalid_o both asserted. Each deasserts independently on its own handshake; sticky aw_done/w_done bits track completion. When both are done, or both complete in the same cycle, go to WRESP.
- WRESP: bready_o=1. On bvalid_i, latch err=(bresp_i!=0) and data=0, then go to RESP.
- RADDR: arvalid_o=1. On arready_i, go to RDATA.
- RDATA: rready_o=1. On rvalid_i, latch rdata_i and err=(rresp_i!=0), then go to RESP.
- RESP: v_o=1, data_o/err_o stable. On ready_and_i, go to IDLE.
- awprot_o=arprot_o=3'b000. awaddr_o=araddr_o=captured addr, unmodified (no realignment). wstrb_o=captured wmask, passed verbatim.
- All AXI payload outputs come from registers and hold stable while the matching valid is high. Valids never drop without a handshake.
- Errors do not stall or retry. The response is delivered with err_o=1.
- bvalid/rvalid arriving in states other than WRESP/RDATA are ignored, since bready_o/rready_o are 0 there.

## Timing
- Reset (reset_n_i=0, asynchronous) forces: state=IDLE; ready_and_o=0 (gated by reset); awvalid/wvalid/arvalid/bready/rready/v_o=0; err_o=0; data_o=0. The first accept is possible in the first cycle after release.
- Reset mid-transaction abandons the transaction immediately and issues no response. The AXI side is assumed reset together.
- Write with zero-wait slave: accept at cycle N; aw/w valid at N+1; bready at N+2 with bvalid; v_o at N+3.
- Read with zero-wait slave: accept N; arvalid N+1; rready N+2 with rvalid; v_o N+3.
- A new request is accepted in the cycle after the response handshake, so peak throughput is 1 transaction per 4 cycles.
- awready, wready and arready stalls of any length extend only their own state. aw and w may complete in either order.

## Test plan
- Write addr=0x1000_0010, data=0xDEAD_BEEF, wmask=0xF, slave ready immediately -> awaddr=0x1000_0010, wdata=0xDEADBEEF, wstrb=0xF; v_o at accept+3, data_o=0, err_o=0.
- Read addr=0x1000_0004; slave returns rdata=0x1234_5678, rresp=OKAY after 5-cycle arready delay -> v_o with data_o=0x12345678, err_o=0, arvalid held 6 cycles with stable araddr.
- Write with wready 3 cycles before awready, then awready first on a second write -> both complete. bready asserts only after both handshakes. wvalid drops after its own handshake.
- Read with rresp=2'b10 (SLVERR) -> v_o with err_o=1, data_o=rdata_i. Next request accepted normally.
- Response backpressure: ready_and_i=0 for 10 cycles -> v_o/data_o stable, ready_and_o=0, no new AXI activity. On ready_and_i=1, ready_and_o=1 the next cycle.
- Assert reset_n_i during RDATA -> all valids and readies 0 immediately, no v_o. After release, a read of 0x20 completes correctly.

Source files
------------

// File: rtl/axil_fifo_master_if.sv
// ---------------------------------------------------------------------------
// axil_fifo_master_if
//
// Bundles the two sides of the axil_fifo_master bridge:
//   * the local request stream   (addr_i/data_i/w_i/wmask_i/v_i -> ready_and_o)
//   * the local response stream  (data_o/err_o/v_o -> ready_and_i)
//   * a standard AXI4-Lite master port (AW, W, B, AR, R channels)
//
// Signal names keep the _i/_o suffix as seen from the bridge itself, so the
// "master" modport is the bridge view and "slave" is the environment view
// (request agent plus the AXI-lite slave it talks to).
// ---------------------------------------------------------------------------
interface axil_fifo_master_if #(
    parameter int axil_data_width_p = 32,
    parameter int axil_addr_width_p = 32
);
    localparam int axil_mask_width_lp = axil_data_width_p / 8;

    // local request stream
    logic [axil_addr_width_p-1:0]  addr_i;
    logic [axil_data_width_p-1:0]  data_i;
    logic                          w_i;
    logic [axil_mask_width_lp-1:0] wmask_i;
    logic                          v_i;
    logic                          ready_and_o;

    // local response stream
    logic [axil_data_width_p-1:0]  data_o;
    logic                          err_o;
    logic                          v_o;
    logic                          ready_and_i;

    // AXI4-Lite write address channel
    logic [axil_addr_width_p-1:0]  m_axil_awaddr_o;
    logic [2:0]                    m_axil_awprot_o;
    logic                          m_axil_awvalid_o;
    logic                          m_axil_awready_i;

    // AXI4-Lite write data channel
    logic [axil_data_width_p-1:0]  m_axil_wdata_o;
    logic [axil_mask_width_lp-1:0] m_axil_wstrb_o;
    logic                          m_axil_wvalid_o;
    logic                          m_axil_wready_i;

    // AXI4-Lite write response channel
    logic [1:0]                    m_axil_bresp_i;
    logic                          m_axil_bvalid_i;
    logic                          m_axil_bready_o;

    // AXI4-Lite read address channel
    logic [axil_addr_width_p-1:0]  m_axil_araddr_o;
    logic [2:0]                    m_axil_arprot_o;
    logic                          m_axil_arvalid_o;
    logic                          m_axil_arready_i;

    // AXI4-Lite read data channel
    logic [axil_data_width_p-1:0]  m_axil_rdata_i;
    logic [1:0]                    m_axil_rresp_i;
    logic                          m_axil_rvalid_i;
    logic                          m_axil_rready_o;

    modport master (
        input  addr_i, data_i, w_i, wmask_i, v_i,
        output ready_and_o,
        output data_o, err_o, v_o,
        input  ready_and_i,
        output m_axil_awaddr_o, m_axil_awprot_o, m_axil_awvalid_o,
        input  m_axil_awready_i,
        output m_axil_wdata_o, m_axil_wstrb_o, m_axil_wvalid_o,
        input  m_axil_wready_i,
        input  m_axil_bresp_i, m_axil_bvalid_i,
        output m_axil_bready_o,
        output m_axil_araddr_o, m_axil_arprot_o, m_axil_arvalid_o,
        input  m_axil_arready_i,
        input  m_axil_rdata_i, m_axil_rresp_i, m_axil_rvalid_i,
        output m_axil_rready_o
    );

    modport slave (
        output addr_i, data_i, w_i, wmask_i, v_i,
        input  ready_and_o,
        input  data_o, err_o, v_o,
        output ready_and_i,
        input  m_axil_awaddr_o, m_axil_awprot_o, m_axil_awvalid_o,
        output m_axil_awready_i,
        input  m_axil_wdata_o, m_axil_wstrb_o, m_axil_wvalid_o,
        output m_axil_wready_i,
        output m_axil_bresp_i, m_axil_bvalid_i,
        input  m_axil_bready_o,
        input  m_axil_araddr_o, m_axil_arprot_o, m_axil_arvalid_o,
        output m_axil_arready_i,
        output m_axil_rdata_i, m_axil_rresp_i, m_axil_rvalid_i,
        input  m_axil_rready_o
    );
endinterface

// File: rtl/axil_fifo_master.sv
// ---------------------------------------------------------------------------
// axil_fifo_master
//
// Turns a valid/ready request stream (addr/data/write/wmask) into single
// AXI4-Lite transactions, one outstanding at a time, and returns the read
// data (or zero for a write) plus an error flag on a valid/ready response
// stream. Non-OKAY responses are passed through as err_o=1, never retried.
//
// Ports:
//   clk_i      - single clock, all logic on the rising edge
//   reset_n_i  - asynchronous active-low reset
//   bus        - axil_fifo_master_if.master: request stream, response
//                stream and the AXI4-Lite master channels
// ---------------------------------------------------------------------------
module axil_fifo_master #(
    parameter int axil_data_width_p = 32,
    parameter int axil_addr_width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    axil_fifo_master_if.master bus
);
    localparam int axil_mask_width_lp = axil_data_width_p / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA,
        ST_RESP
    } state_t;

    // registered state and captured request / response
    state_t                        r_state;
    logic [axil_addr_width_p-1:0]  r_addr;
    logic [axil_data_width_p-1:0]  r_wdata;
    logic [axil_mask_width_lp-1:0] r_wmask;
    logic                          r_aw_done;
    logic                          r_w_done;
    logic [axil_data_width_p-1:0]  r_rsp_data;
    logic                          r_rsp_err;

    // next-state values
    state_t                        w_state_next;
    logic [axil_addr_width_p-1:0]  w_addr_next;
    logic [axil_data_width_p-1:0]  w_wdata_next;
    logic [axil_mask_width_lp-1:0] w_wmask_next;
    logic                          w_aw_done_next;
    logic                          w_w_done_next;
    logic [axil_data_width_p-1:0]  w_rsp_data_next;
    logic                          w_rsp_err_next;

    // decoded outputs
    logic w_ready_and;
    logic w_awvalid;
    logic w_wvalid;
    logic w_bready;
    logic w_arvalid;
    logic w_rready;
    logic w_v;
    logic w_aw_hs;
    logic w_w_hs;

    // ready_and_o is gated directly by the reset pin so no request can be
    // accepted while reset is held, even combinationally.
    assign w_ready_and = (r_state == ST_IDLE) && reset_n_i;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wmask    <= '0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_addr     <= w_addr_next;
            r_wdata    <= w_wdata_next;
            r_wmask    <= w_wmask_next;
            r_aw_done  <= w_aw_done_next;
            r_w_done   <= w_w_done_next;
            r_rsp_data <= w_rsp_data_next;
            r_rsp_err  <= w_rsp_err_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_addr_next     = r_addr;
        w_wdata_next    = r_wdata;
        w_wmask_next    = r_wmask;
        w_aw_done_next  = r_aw_done;
        w_w_done_next   = r_w_done;
        w_rsp_data_next = r_rsp_data;
        w_rsp_err_next  = r_rsp_err;

        w_awvalid = 1'b0;
        w_wvalid  = 1'b0;
        w_bready  = 1'b0;
        w_arvalid = 1'b0;
        w_rready  = 1'b0;
        w_v       = 1'b0;
        w_aw_hs   = 1'b0;
        w_w_hs    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.v_i && w_ready_and) begin
                    w_addr_next    = bus.addr_i;
                    w_wdata_next   = bus.data_i;
                    w_wmask_next   = bus.wmask_i;
                    w_aw_done_next = 1'b0;
                    w_w_done_next  = 1'b0;
                    w_state_next   = bus.w_i ? ST_WRITE : ST_RADDR;
                end
            end

            ST_WRITE: begin
                // AW and W are independent: each valid drops on its own
                // handshake, and the sticky done bits remember which side
                // already finished so either order (or both at once) works.
                w_awvalid      = !r_aw_done;
                w_wvalid       = !r_w_done;
                w_aw_hs        = w_awvalid && bus.m_axil_awready_i;
                w_w_hs         = w_wvalid && bus.m_axil_wready_i;
                w_aw_done_next = r_aw_done || w_aw_hs;
                w_w_done_next  = r_w_done || w_w_hs;
                if (w_aw_done_next && w_w_done_next) begin
                    w_state_next = ST_WRESP;
                end
            end

            ST_WRESP: begin
                w_bready = 1'b1;
                if (bus.m_axil_bvalid_i) begin
                    w_rsp_data_next = '0;
                    w_rsp_err_next  = (bus.m_axil_bresp_i != 2'b00);
                    w_state_next    = ST_RESP;
                end
            end

            ST_RADDR: begin
                w_arvalid = 1'b1;
                if (bus.m_axil_arready_i) begin
                    w_state_next = ST_RDATA;
                end
            end

            ST_RDATA: begin
                w_rready = 1'b1;
                if (bus.m_axil_rvalid_i) begin
                    w_rsp_data_next = bus.m_axil_rdata_i;
                    w_rsp_err_next  = (bus.m_axil_rresp_i != 2'b00);
                    w_state_next    = ST_RESP;
                end
            end

            ST_RESP: begin
                w_v = 1'b1;
                if (bus.ready_and_i) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output wiring: payloads come straight from the capture registers,
    // so they hold for as long as the matching valid is asserted.
    // ------------------------------------------------------------------
    assign bus.ready_and_o      = w_ready_and;
    assign bus.data_o           = r_rsp_data;
    assign bus.err_o            = r_rsp_err;
    assign bus.v_o              = w_v;

    assign bus.m_axil_awaddr_o  = r_addr;
    assign bus.m_axil_awprot_o  = 3'b000;
    assign bus.m_axil_awvalid_o = w_awvalid;

    assign bus.m_axil_wdata_o   = r_wdata;
    assign bus.m_axil_wstrb_o   = r_wmask;
    assign bus.m_axil_wvalid_o  = w_wvalid;

    assign bus.m_axil_bready_o  = w_bready;

    assign bus.m_axil_araddr_o  = r_addr;
    assign bus.m_axil_arprot_o  = 3'b000;
    assign bus.m_axil_arvalid_o = w_arvalid;

    assign bus.m_axil_rready_o  = w_rready;

endmodule

// File: tb/tb_axil_fifo_master.sv
module tb_axil_fifo_master;

    logic clk;
    logic rst_n;

    int n_cmp = 0;
    int n_mis = 0;

    axil_fifo_master_if #(.axil_data_width_p(32), .axil_addr_width_p(32)) bus_if ();

    axil_fifo_master #(.axil_data_width_p(32), .axil_addr_width_p(32)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'hA500_0000 | (i << 12) | (i * 7);
    endfunction

    // ------------------------------------------------------------------
    // Slave controls (written by the tests) and slave observations
    // (written only by the slave process)
    // ------------------------------------------------------------------
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    bit          rd_ovr_en = 0;
    logic [31:0] rd_ovr = 0;

    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    logic [2:0]  s_awprot, s_arprot;
    int          aw_viol = 0, w_viol = 0, b_early = 0, ar_cycles = 0, ar_changes = 0;

    logic [31:0] smem [0:255];

    // AXI-lite slave: decisions are made on the falling edge; a ready or
    // valid raised here against a DUT valid/ready already high completes at
    // the next rising edge.
    initial begin : slave
        bit aw_got, w_got, ar_got, b_fire, r_fire, both_prev, ar_prev, ar_pv;
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        logic [31:0] ar_pa;
        aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0; ar_pv = 0; ar_pa = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        for (int i = 0; i < 256; i++) smem[i] = init_word(i);
        bus_if.m_axil_awready_i = 0;
        bus_if.m_axil_wready_i  = 0;
        bus_if.m_axil_bvalid_i  = 0;
        bus_if.m_axil_bresp_i   = 0;
        bus_if.m_axil_arready_i = 0;
        bus_if.m_axil_rvalid_i  = 0;
        bus_if.m_axil_rresp_i   = 0;
        bus_if.m_axil_rdata_i   = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0; ar_pv = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                bus_if.m_axil_awready_i = 0;
                bus_if.m_axil_wready_i  = 0;
                bus_if.m_axil_bvalid_i  = 0;
                bus_if.m_axil_arready_i = 0;
                bus_if.m_axil_rvalid_i  = 0;
            end else begin
                // protocol observations
                if (aw_got && bus_if.m_axil_awvalid_o) aw_viol++;
                if (w_got && bus_if.m_axil_wvalid_o) w_viol++;
                if (bus_if.m_axil_bready_o && !(aw_got && w_got)) b_early++;
                if (bus_if.m_axil_arvalid_o) begin
                    ar_cycles++;
                    if (ar_pv && bus_if.m_axil_araddr_o !== ar_pa) ar_changes++;
                end
                ar_pv = bus_if.m_axil_arvalid_o;
                ar_pa = bus_if.m_axil_araddr_o;
                // completed responses
                if (b_fire) begin bus_if.m_axil_bvalid_i = 0; aw_got = 0; w_got = 0; b_fire = 0; end
                if (r_fire) begin bus_if.m_axil_rvalid_i = 0; ar_got = 0; r_fire = 0; end
                both_prev = aw_got && w_got;
                ar_prev   = ar_got;
                // AW
                bus_if.m_axil_awready_i = 0;
                if (bus_if.m_axil_awvalid_o && !aw_got) begin
                    if (aw_cnt >= aw_delay) begin
                        bus_if.m_axil_awready_i = 1; aw_got = 1; aw_cnt = 0;
                        s_awaddr = bus_if.m_axil_awaddr_o; s_awprot = bus_if.m_axil_awprot_o;
                    end else aw_cnt++;
                end
                // W
                bus_if.m_axil_wready_i = 0;
                if (bus_if.m_axil_wvalid_o && !w_got) begin
                    if (w_cnt >= w_delay) begin
                        bus_if.m_axil_wready_i = 1; w_got = 1; w_cnt = 0;
                        s_wdata = bus_if.m_axil_wdata_o; s_wstrb = bus_if.m_axil_wstrb_o;
                    end else w_cnt++;
                end
                // AR
                bus_if.m_axil_arready_i = 0;
                if (bus_if.m_axil_arvalid_o && !ar_got) begin
                    if (ar_cnt >= ar_delay) begin
                        bus_if.m_axil_arready_i = 1; ar_got = 1; ar_cnt = 0;
                        s_araddr = bus_if.m_axil_araddr_o; s_arprot = bus_if.m_axil_arprot_o;
                    end else ar_cnt++;
                end
                // B: addresses with bit 10 set answer SLVERR and are not written
                if (both_prev && !bus_if.m_axil_bvalid_i) begin
                    if (b_cnt >= b_delay) begin
                        b_cnt = 0;
                        bus_if.m_axil_bvalid_i = 1;
                        bus_if.m_axil_bresp_i  = s_awaddr[10] ? 2'b10 : 2'b00;
                        if (!s_awaddr[10])
                            for (int b = 0; b < 4; b++)
                                if (s_wstrb[b]) smem[s_awaddr[9:2]][8*b +: 8] = s_wdata[8*b +: 8];
                    end else b_cnt++;
                end
                // R
                if (ar_prev && !bus_if.m_axil_rvalid_i) begin
                    if (r_cnt >= r_delay) begin
                        r_cnt = 0;
                        bus_if.m_axil_rvalid_i = 1;
                        bus_if.m_axil_rresp_i  = s_araddr[10] ? 2'b10 : 2'b00;
                        bus_if.m_axil_rdata_i  = rd_ovr_en ? rd_ovr : smem[s_araddr[9:2]];
                    end else r_cnt++;
                end
                b_fire = bus_if.m_axil_bvalid_i && bus_if.m_axil_bready_o;
                r_fire = bus_if.m_axil_rvalid_i && bus_if.m_axil_rready_o;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: a byte-addressable word memory mirroring what the
    // slave should hold, updated from the requests themselves.
    // ------------------------------------------------------------------
    logic [31:0] ref_mem [0:255];

    function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        if (!a[10])
            for (int b = 0; b < 4; b++)
                if (m[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
    endfunction

    // ------------------------------------------------------------------
    // Requester: one transaction, with response backpressure of bp cycles
    // ------------------------------------------------------------------
    task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic wr,
                           input logic [3:0] m, input int bp,
                           output logic [31:0] rd, output logic er, output int lat,
                           output int bpv, output logic rdy_after);
        int n;
        rd = 0; er = 0; lat = 0; bpv = 0; rdy_after = 0;
        @(negedge clk);
        bus_if.addr_i = a; bus_if.data_i = d; bus_if.w_i = wr; bus_if.wmask_i = m;
        bus_if.v_i = 1; bus_if.ready_and_i = 0;
        n = 0;
        while (!bus_if.ready_and_o && n < 100) begin @(negedge clk); n++; end
        n_cmp++;
        if (!bus_if.ready_and_o) begin
            n_mis++; bus_if.v_i = 0;
            $display("FAIL accept_timeout: ready_and_o=%b required 1 within 100 cycles", bus_if.ready_and_o);
            return;
        end
        @(negedge clk);
        bus_if.v_i = 0;
        lat = 1;
        while (!bus_if.v_o && lat < 200) begin @(negedge clk); lat++; end
        n_cmp++;
        if (!bus_if.v_o) begin
            n_mis++;
            $display("FAIL response_timeout: v_o=%b required 1 within 200 cycles", bus_if.v_o);
            return;
        end
        rd = bus_if.data_o; er = bus_if.err_o;
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            if (bus_if.v_o !== 1'b1 || bus_if.data_o !== rd || bus_if.err_o !== er ||
                bus_if.ready_and_o !== 1'b0 ||
                {bus_if.m_axil_awvalid_o, bus_if.m_axil_wvalid_o, bus_if.m_axil_arvalid_o,
                 bus_if.m_axil_bready_o, bus_if.m_axil_rready_o} !== 5'b0)
                bpv++;
        end
        bus_if.ready_and_i = 1;
        @(negedge clk);
        bus_if.ready_and_i = 0;
        rdy_after = bus_if.ready_and_o;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus_if.ready_and_o, bus_if.m_axil_awvalid_o, bus_if.m_axil_wvalid_o, bus_if.m_axil_arvalid_o,
             bus_if.m_axil_bready_o, bus_if.m_axil_rready_o, bus_if.v_o, bus_if.err_o} !== 8'b0) begin
            n_mis++;
            $display("FAIL reset_ctrl: rdy/aw/w/ar/b/r/v/err=%b required 00000000",
                     {bus_if.ready_and_o, bus_if.m_axil_awvalid_o, bus_if.m_axil_wvalid_o, bus_if.m_axil_arvalid_o,
                      bus_if.m_axil_bready_o, bus_if.m_axil_rready_o, bus_if.v_o, bus_if.err_o});
        end
        n_cmp++;
        if (bus_if.data_o !== 32'h0) begin
            n_mis++; $display("FAIL reset_data: data_o=%h required 00000000", bus_if.data_o);
        end
        #2 rst_n = 1;
        @(negedge clk);
        n_cmp++;
        if (bus_if.ready_and_o !== 1'b1) begin
            n_mis++; $display("FAIL reset_release_ready: ready_and_o=%b required 1", bus_if.ready_and_o);
        end
        $display("reset: released, ready_and_o=%b", bus_if.ready_and_o);
    endtask

    task automatic test_write_basic();
        logic [31:0] rd; logic er, ra; int lat, bpv;
        aw_delay = 0; w_delay = 0; b_delay = 0;
        run_txn(32'h1000_0010, 32'hDEAD_BEEF, 1'b1, 4'hF, 0, rd, er, lat, bpv, ra);
        ref_write(32'h1000_0010, 32'hDEAD_BEEF, 4'hF);
        $display("write_basic: addr=10000010 lat=%0d data_o=%h err=%b awaddr=%h wdata=%h wstrb=%h",
                 lat, rd, er, s_awaddr, s_wdata, s_wstrb);
        n_cmp++; if (lat !== 3) begin n_mis++; $display("FAIL wb_latency: %0d required 3", lat); end
        n_cmp++; if (rd !== 32'h0) begin n_mis++; $display("FAIL wb_data: %h required 00000000", rd); end
        n_cmp++; if (er !== 1'b0) begin n_mis++; $display("FAIL wb_err: %b required 0", er); end
        n_cmp++; if (s_awaddr !== 32'h1000_0010) begin n_mis++; $display("FAIL wb_awaddr: %h required 10000010", s_awaddr); end
        n_cmp++; if (s_wdata !== 32'hDEAD_BEEF) begin n_mis++; $display("FAIL wb_wdata: %h required deadbeef", s_wdata); end
        n_cmp++; if (s_wstrb !== 4'hF) begin n_mis++; $display("FAIL wb_wstrb: %h required f", s_wstrb); end
        n_cmp++; if (s_awprot !== 3'b000) begin n_mis++; $display("FAIL wb_awprot: %b required 000", s_awprot); end
    endtask

    task automatic test_read_delay();
        logic [31:0] rd; logic er, ra; int lat, bpv, c0, ch0;
        ar_delay = 5; r_delay = 0; rd_ovr_en = 1; rd_ovr = 32'h1234_5678;
        c0 = ar_cycles; ch0 = ar_changes;
        run_txn(32'h1000_0004, 32'h0, 1'b0, 4'h0, 0, rd, er, lat, bpv, ra);
        rd_ovr_en = 0; ar_delay = 0;
        $display("read_delay: addr=10000004 lat=%0d data_o=%h err=%b arvalid_cycles=%0d araddr=%h",
                 lat, rd, er, ar_cycles - c0, s_araddr);
        n_cmp++; if (rd !== 32'h1234_5678) begin n_mis++; $display("FAIL rd_data: %h required 12345678", rd); end
        n_cmp++; if (er !== 1'b0) begin n_mis++; $display("FAIL rd_err: %b required 0", er); end
        n_cmp++; if (ar_cycles - c0 !== 6) begin n_mis++; $display("FAIL rd_arvalid_cycles: %0d required 6", ar_cycles - c0); end
        n_cmp++; if (ar_changes - ch0 !== 0) begin n_mis++; $display("FAIL rd_araddr_stable: %0d changes required 0", ar_changes - ch0); end
        n_cmp++; if (s_araddr !== 32'h1000_0004) begin n_mis++; $display("FAIL rd_araddr: %h required 10000004", s_araddr); end
        n_cmp++; if (lat !== 8) begin n_mis++; $display("FAIL rd_latency: %0d required 8", lat); end
        n_cmp++; if (s_arprot !== 3'b000) begin n_mis++; $display("FAIL rd_arprot: %b required 000", s_arprot); end
    endtask

    task automatic test_write_order();
        logic [31:0] rd; logic er, ra; int lat, bpv, av0, wv0, be0;
        av0 = aw_viol; wv0 = w_viol; be0 = b_early;
        // W first
        aw_delay = 3; w_delay = 0;
        run_txn(32'h0000_0040, 32'h0BAD_F00D, 1'b1, 4'hF, 0, rd, er, lat, bpv, ra);
        ref_write(32'h0000_0040, 32'h0BAD_F00D, 4'hF);
        $display("write_w_first: addr=00000040 lat=%0d err=%b", lat, er);
        n_cmp++; if (lat !== 6) begin n_mis++; $display("FAIL wo1_latency: %0d required 6", lat); end
        // AW first, partial strobes
        aw_delay = 0; w_delay = 4;
        run_txn(32'h0000_0044, 32'hCAFE_1234, 1'b1, 4'h5, 0, rd, er, lat, bpv, ra);
        ref_write(32'h0000_0044, 32'hCAFE_1234, 4'h5);
        $display("write_aw_first: addr=00000044 lat=%0d err=%b wstrb=%h", lat, er, s_wstrb);
        aw_delay = 0; w_delay = 0;
        n_cmp++; if (lat !== 7) begin n_mis++; $display("FAIL wo2_latency: %0d required 7", lat); end
        n_cmp++; if (s_wstrb !== 4'h5) begin n_mis++; $display("FAIL wo2_wstrb: %h required 5", s_wstrb); end
        n_cmp++; if (aw_viol - av0 !== 0) begin n_mis++; $display("FAIL wo_awvalid_drop: %0d late cycles required 0", aw_viol - av0); end
        n_cmp++; if (w_viol - wv0 !== 0) begin n_mis++; $display("FAIL wo_wvalid_drop: %0d late cycles required 0", w_viol - wv0); end
        n_cmp++; if (b_early - be0 !== 0) begin n_mis++; $display("FAIL wo_bready_early: %0d cycles required 0", b_early - be0); end
        // read back the partially written word
        run_txn(32'h0000_0044, 32'h0, 1'b0, 4'h0, 0, rd, er, lat, bpv, ra);
        $display("readback: addr=00000044 data_o=%h expected=%h", rd, ref_mem[17]);
        n_cmp++; if (rd !== ref_mem[17]) begin n_mis++; $display("FAIL wo_readback: %h required %h", rd, ref_mem[17]); end
    endtask

    task automatic test_read_err();
        logic [31:0] rd; logic er, ra; int lat, bpv;
        run_txn(32'h0000_0408, 32'h0, 1'b0, 4'h0, 0, rd, er, lat, bpv, ra);
        $display("read_slverr: addr=00000408 data_o=%h err=%b", rd, er);
        n_cmp++; if (er !== 1'b1) begin n_mis++; $display("FAIL re_err: %b required 1", er); end
        n_cmp++; if (rd !== ref_mem[2]) begin n_mis++; $display("FAIL re_data: %h required %h", rd, ref_mem[2]); end
        run_txn(32'h0000_000C, 32'h0, 1'b0, 4'h0, 0, rd, er, lat, bpv, ra);
        $display("read_after_err: addr=0000000c data_o=%h err=%b lat=%0d", rd, er, lat);
        n_cmp++; if (er !== 1'b0 || rd !== ref_mem[3]) begin n_mis++; $display("FAIL re_next: err=%b data=%h required 0/%h", er, rd, ref_mem[3]); end
        n_cmp++; if (lat !== 3) begin n_mis++; $display("FAIL re_next_latency: %0d required 3", lat); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er, ra; int lat, bpv;
        run_txn(32'h0000_0010, 32'h0, 1'b0, 4'h0, 10, rd, er, lat, bpv, ra);
        $display("backpressure: addr=00000010 data_o=%h bad_cycles=%0d ready_after=%b", rd, bpv, ra);
        n_cmp++; if (bpv !== 0) begin n_mis++; $display("FAIL bp_stable: %0d bad cycles required 0", bpv); end
        n_cmp++; if (ra !== 1'b1) begin n_mis++; $display("FAIL bp_ready_after: %b required 1", ra); end
        n_cmp++; if (rd !== ref_mem[4]) begin n_mis++; $display("FAIL bp_data: %h required %h", rd, ref_mem[4]); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er, ra; int lat, bpv, n, vseen;
        r_delay = 6;
        @(negedge clk);
        bus_if.addr_i = 32'h0000_0030; bus_if.w_i = 0; bus_if.v_i = 1; bus_if.ready_and_i = 1;
        @(negedge clk);
        bus_if.v_i = 0;
        n = 0;
        while (!bus_if.m_axil_rready_o && n < 30) begin @(negedge clk); n++; end
        n_cmp++;
        if (!bus_if.m_axil_rready_o) begin n_mis++; $display("FAIL rm_reach_rdata: rready_o=%b required 1", bus_if.m_axil_rready_o); end
        #2 rst_n = 0;
        #1;
        n_cmp++;
        if ({bus_if.ready_and_o, bus_if.m_axil_awvalid_o, bus_if.m_axil_wvalid_o, bus_if.m_axil_arvalid_o,
             bus_if.m_axil_bready_o, bus_if.m_axil_rready_o, bus_if.v_o} !== 7'b0) begin
            n_mis++;
            $display("FAIL rm_immediate: rdy/aw/w/ar/b/r/v=%b required 0000000",
                     {bus_if.ready_and_o, bus_if.m_axil_awvalid_o, bus_if.m_axil_wvalid_o, bus_if.m_axil_arvalid_o,
                      bus_if.m_axil_bready_o, bus_if.m_axil_rready_o, bus_if.v_o});
        end
        vseen = 0;
        repeat (3) begin @(negedge clk); if (bus_if.v_o) vseen++; end
        r_delay = 0;
        #2 rst_n = 1;
        repeat (3) begin @(negedge clk); if (bus_if.v_o) vseen++; end
        bus_if.ready_and_i = 0;
        n_cmp++; if (vseen !== 0) begin n_mis++; $display("FAIL rm_no_response: v_o high %0d cycles required 0", vseen); end
        run_txn(32'h0000_0020, 32'h0, 1'b0, 4'h0, 0, rd, er, lat, bpv, ra);
        $display("reset_mid: post-reset read addr=00000020 data_o=%h err=%b lat=%0d", rd, er, lat);
        n_cmp++; if (rd !== ref_mem[8] || er !== 1'b0) begin n_mis++; $display("FAIL rm_read: data=%h err=%b required %h/0", rd, er, ref_mem[8]); end
        n_cmp++; if (lat !== 3) begin n_mis++; $display("FAIL rm_latency: %0d required 3", lat); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, rd, exp_d; logic wr, er, exp_e, ra; logic [3:0] m; int lat, bpv;
        for (int t = 0; t < 40; t++) begin
            wr = $urandom_range(0, 1);
            a  = ($urandom_range(0, 3) == 0 ? 32'h400 : 32'h0) | ($urandom_range(0, 15) << 2);
            d  = $urandom;
            m  = $urandom_range(0, 15);
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
            ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
            exp_e = a[10];
            exp_d = wr ? 32'h0 : ref_mem[a[9:2]];
            run_txn(a, d, wr, m, $urandom_range(0, 2), rd, er, lat, bpv, ra);
            if (wr) ref_write(a, d, m);
            $display("rand %0d: %s addr=%h wdata=%h mask=%h -> data_o=%h err=%b (exp %h/%b) lat=%0d",
                     t, wr ? "WR" : "RD", a, d, m, rd, er, exp_d, exp_e, lat);
            n_cmp++; if (rd !== exp_d) begin n_mis++; $display("FAIL rand_data[%0d]: %h required %h", t, rd, exp_d); end
            n_cmp++; if (er !== exp_e) begin n_mis++; $display("FAIL rand_err[%0d]: %b required %b", t, er, exp_e); end
            n_cmp++; if (bpv !== 0 || ra !== 1'b1) begin n_mis++; $display("FAIL rand_handoff[%0d]: bad=%0d ready_after=%b required 0/1", t, bpv, ra); end
            if (wr) begin
                n_cmp++;
                if (s_awaddr !== a || s_wdata !== d || s_wstrb !== m) begin
                    n_mis++;
                    $display("FAIL rand_wpayload[%0d]: %h/%h/%h required %h/%h/%h", t, s_awaddr, s_wdata, s_wstrb, a, d, m);
                end
            end else begin
                n_cmp++;
                if (s_araddr !== a) begin n_mis++; $display("FAIL rand_araddr[%0d]: %h required %h", t, s_araddr, a); end
            end
        end
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        rst_n = 0;
        bus_if.addr_i = 0; bus_if.data_i = 0; bus_if.w_i = 0; bus_if.wmask_i = 0;
        bus_if.v_i = 0; bus_if.ready_and_i = 0;
        test_reset();
        test_write_basic();
        test_read_delay();
        test_write_order();
        test_read_err();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded 500000 time units");
        $fatal(1, "timeout");
    end

endmodule
